// File: rtl/decode_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_pkg
// Purpose  : Shared definitions for the decode-then-select unit: the default
//            select width, the supported width range and a one-hot helper
//            that returns a vector sized for the largest supported width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package decode_mux_pkg;

  localparam int DEFAULT_SEL_W = 2;
  localparam int MAX_SEL_W     = 4;
  localparam int MAX_N         = 2 ** MAX_SEL_W;

  // One-hot of idx when en is set, otherwise all-zero. Callers with a
  // narrower SEL_W take the low 2**SEL_W bits of the result.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx,
                                              input logic                 en);
    logic [MAX_N-1:0] v;
    v = '0;
    if (en) begin
      v[idx] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_mux_unit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Purpose  : Purely combinational enable-gated binary-to-one-hot decoder.
// Ports    : en       - enable; low forces every output low
//            dec_in   - SEL_W-bit binary index
//            dec_comb - 2**SEL_W one-hot result (all-zero when en is low)
// Revision : 1.0  initial release
// ============================================================================
module onehot_decoder
  import decode_mux_pkg::*;
#(
  parameter int SEL_W = DEFAULT_SEL_W
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      dec_in,
  output logic [(2**SEL_W)-1:0] dec_comb
);

  localparam int N = 2 ** SEL_W;

  for (genvar k = 0; k < N; k++) begin : g_dec
    assign dec_comb[k] = en & (dec_in == SEL_W'(k));
  end

endmodule
`default_nettype wire

// File: rtl/decode_mux_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_unit
// Purpose  : Registered decode-then-select unit. An enable-gated decoder
//            feeds the data inputs of a 2**SEL_W:1 mux whose select comes
//            from an independent input; the one-hot vector and the mux
//            result are registered together with a one-cycle valid flag.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous active-high reset
//            in_valid  - qualifies en / dec_in / mux_sel this cycle
//            en        - decoder enable
//            dec_in    - binary decoder input
//            mux_sel   - mux select
//            dec_out   - registered one-hot decode
//            y         - registered mux output (decoded bit at mux_sel)
//            out_valid - high one cycle after an accepted in_valid
// Revision : 1.0  initial release
// ============================================================================
module decode_mux_unit
  import decode_mux_pkg::*;
#(
  parameter int SEL_W = DEFAULT_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  en,
  input  logic [SEL_W-1:0]      dec_in,
  input  logic [SEL_W-1:0]      mux_sel,
  output logic [(2**SEL_W)-1:0] dec_out,
  output logic                  y,
  output logic                  out_valid
);

  localparam int N = 2 ** SEL_W;

  logic [N-1:0] dec_comb;
  logic         y_comb;

  logic [N-1:0] dec_out_d, dec_out_q;
  logic         y_d, y_q;
  logic         out_valid_d, out_valid_q;

  onehot_decoder #(
    .SEL_W    (SEL_W)
  ) u_decoder (
    .en       (en),
    .dec_in   (dec_in),
    .dec_comb (dec_comb)
  );

  // Every SEL_W value is a legal index into an N-entry vector, so no range
  // guard is needed on the select.
  assign y_comb = dec_comb[mux_sel];

  // Data registers hold while idle; the valid flag is a single-cycle pulse.
  always_comb begin
    dec_out_d   = dec_out_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      dec_out_d   = dec_comb;
      y_d         = y_comb;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_out_q   <= '0;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dec_out_q   <= dec_out_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dec_out   = dec_out_q;
  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_mux_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_mux_unit
// Purpose  : Scoreboard bench for decode_mux_unit at SEL_W=2 and SEL_W=3.
//            The driver pushes the expected registered state for every
//            cycle of the SEL_W=2 instance; monitors pop and compare on the
//            falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_mux_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SEL_W = 2 instance
  logic       rst, in_valid, en;
  logic [1:0] dec_in, mux_sel;
  logic [3:0] dec_out;
  logic       y, out_valid;

  // SEL_W = 3 instance
  logic       in_valid8, en8;
  logic [2:0] dec_in8, mux_sel8;
  logic [7:0] dec_out8;
  logic       y8, out_valid8;

  decode_mux_unit #(.SEL_W(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .en        (en),
    .dec_in    (dec_in),
    .mux_sel   (mux_sel),
    .dec_out   (dec_out),
    .y         (y),
    .out_valid (out_valid)
  );

  decode_mux_unit #(.SEL_W(3)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .en        (en8),
    .dec_in    (dec_in8),
    .mux_sel   (mux_sel8),
    .dec_out   (dec_out8),
    .y         (y8),
    .out_valid (out_valid8)
  );

  typedef struct {
    string      tag;
    logic       ov;
    logic [3:0] dec;
    logic       y;
  } exp4_t;

  typedef struct {
    string      tag;
    logic [7:0] dec;
    logic       y;
  } exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];

  int checks = 0;
  int errors = 0;

  // Reference state of the SEL_W=2 instance.
  logic [3:0] m_dec = 4'b0000;
  logic       m_y   = 1'b0;

  // One clock of stimulus. Inputs are applied, the edge is taken, and the
  // expected post-edge state is queued; the monitor compares it at negedge.
  task automatic drive(input string tag, input logic r, input logic v,
                       input logic e, input logic [1:0] d, input logic [1:0] s,
                       input logic [3:0] want_dec, input logic want_y);
    exp4_t x;
    exp8_t x8;
    rst = r; in_valid = v; en = e; dec_in = d; mux_sel = s;
    @(posedge clk);
    if (r) begin
      m_dec = 4'b0000; m_y = 1'b0;
    end else if (v) begin
      m_dec = want_dec; m_y = want_y;
    end
    x.tag = tag; x.ov = v & ~r; x.dec = m_dec; x.y = m_y;
    q4.push_back(x);
    if (in_valid8 && !r) begin
      x8.tag = tag;
      x8.dec = en8 ? (8'h01 << dec_in8) : 8'h00;
      x8.y   = en8 && (dec_in8 == mux_sel8);
      q8.push_back(x8);
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp4_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if (out_valid !== e.ov || dec_out !== e.dec || y !== e.y) begin
        errors++;
        $display("FAIL %s: got ov=%b dec=%b y=%b, want ov=%b dec=%b y=%b",
                 e.tag, out_valid, dec_out, y, e.ov, e.dec, e.y);
      end
    end
  end

  always @(negedge clk) begin
    exp8_t e;
    if (out_valid8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected: got out_valid8=1, want no output");
      end else begin
        e = q8.pop_front();
        if (dec_out8 !== e.dec || y8 !== e.y) begin
          errors++;
          $display("FAIL %s: got dec=%h y=%b, want dec=%h y=%b",
                   e.tag, dec_out8, y8, e.dec, e.y);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] wd;
    logic [1:0] dd, ss;
    rst = 1'b1; in_valid = 1'b0; en = 1'b0; dec_in = '0; mux_sel = '0;
    in_valid8 = 1'b0; en8 = 1'b0; dec_in8 = '0; mux_sel8 = '0;

    // Reset with live-looking inputs: outputs stay zero.
    drive("reset0", 1, 1, 1, 2'd3, 2'd3, 4'b1000, 1'b1);
    drive("reset1", 1, 1, 1, 2'd3, 2'd3, 4'b1000, 1'b1);

    // Legacy sequence, dec_in=2 -> 0100; mux_sel 2,0,3,1 -> y 1,0,0,0.
    drive("legacy_s2", 0, 1, 1, 2'd2, 2'd2, 4'b0100, 1'b1);
    drive("legacy_s0", 0, 1, 1, 2'd2, 2'd0, 4'b0100, 1'b0);
    drive("legacy_s3", 0, 1, 1, 2'd2, 2'd3, 4'b0100, 1'b0);
    drive("legacy_s1", 0, 1, 1, 2'd2, 2'd1, 4'b0100, 1'b0);

    // Enable off.
    drive("en_off", 0, 1, 0, 2'd2, 2'd2, 4'b0000, 1'b0);

    // Exhaustive sweep at full rate.
    for (int e = 0; e < 2; e++) begin
      for (int d = 0; d < 4; d++) begin
        for (int s = 0; s < 4; s++) begin
          dd = 2'(d); ss = 2'(s);
          wd = (e != 0) ? (4'b0001 << d) : 4'b0000;
          drive("sweep", 0, 1, 1'(e), dd, ss, wd, (e != 0) && (d == s));
        end
      end
    end

    // Load, hold with changing inputs, mid-stream reset, fresh reload.
    drive("load",  0, 1, 1, 2'd1, 2'd1, 4'b0010, 1'b1);
    drive("hold0", 0, 0, 1, 2'd3, 2'd3, 4'b1000, 1'b1);
    drive("hold1", 0, 0, 0, 2'd0, 2'd2, 4'b0000, 1'b0);
    drive("hold2", 0, 0, 1, 2'd2, 2'd2, 4'b0100, 1'b1);
    drive("mid_rst", 1, 0, 1, 2'd2, 2'd2, 4'b0100, 1'b1);
    drive("idle_after_rst", 0, 0, 1, 2'd2, 2'd2, 4'b0100, 1'b1);
    drive("fresh", 0, 1, 1, 2'd3, 2'd3, 4'b1000, 1'b1);

    // SEL_W=3 boundary: MSB decode and select.
    in_valid8 = 1'b1; en8 = 1'b1; dec_in8 = 3'd7; mux_sel8 = 3'd7;
    drive("w8_msb_sel7", 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1'b0);
    mux_sel8 = 3'd6;
    drive("w8_msb_sel6", 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1'b0);
    in_valid8 = 1'b0;
    drive("idle_end0", 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1'b0);
    drive("idle_end1", 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1'b0);

    @(posedge clk);
    #1;
    checks++;
    if (q4.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: got q4=%0d q8=%0d pending, want 0 0", q4.size(), q8.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_mux_unit.md
Name: decode_mux_unit

Overview:
- Registered decode-then-select unit.
- An enable-gated binary-to-one-hot decoder drives the data inputs of a 2^SEL_W:1 multiplexer, whose select comes from an independent input.
- Both the one-hot vector and the mux result are registered on a single clock.
- Used as a small addressing/steering primitive and as a self-checking decoder/mux pair.

Parameters:
- SEL_W, 2, width of decoder input and mux select; N = 2**SEL_W decoder outputs / mux inputs. Legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies en/dec_in/mux_sel this cycle
- en  input  1  decoder enable; 0 forces all decoder outputs low
- dec_in  input  SEL_W  binary decoder input; bit 0 = LSB (legacy i0), bit 1 = legacy i1
- mux_sel  input  SEL_W  mux select; bit 0 = LSB (legacy s0), bit 1 = legacy s1
- dec_out  output  N  registered one-hot decode; bit k = legacy dk
- y  output  1  registered mux output = decoded bit selected by mux_sel
- out_valid  output  1  high one cycle after an accepted in_valid

Behaviour:
- Combinational core, per cycle:
  - dec_comb[k] = en & (dec_in == k) for k = 0..N-1.
  - y_comb = dec_comb[mux_sel].
- Register stage, on rising clk:
  - rst=1: dec_out <= 0, y <= 0, out_valid <= 0. Reset has priority over in_valid.
  - rst=0, in_valid=1: dec_out <= dec_comb, y <= y_comb, out_valid <= 1.
  - rst=0, in_valid=0: dec_out and y hold their previous values; out_valid <= 0.
- Latency: exactly 1 clock from the sampling edge to visible outputs. Back-to-back in_valid is supported at full rate with no stalls.
- Invariants:
  - dec_out is either all-zero (en=0, or after reset) or exactly one-hot.
  - y = 1 if and only if en=1 and mux_sel == dec_in (values sampled at the same edge).
- Boundary conditions:
  - dec_in = N-1 sets the MSB of dec_out.
  - mux_sel = N-1 selects the MSB.
  - No wrap or overflow is possible: every SEL_W value is a valid index.
- Reset mid-stream: outputs clear at that edge; the first in_valid after rst deasserts produces fresh outputs one cycle later.
- X-handling: none required. Inputs are assumed driven whenever in_valid=1.
- Reset value of every output: 0.

Decomposition:
- Shared package decode_mux_pkg:
  - localparam default SEL_W = 2.
  - Function onehot(idx, en) returning the N-bit vector, reusable by the scoreboard.
- Sub-module onehot_decoder (parameter SEL_W; ports en, dec_in, dec_comb), purely combinational.
- Mux select and register stage live in decode_mux_unit itself; no separate mux module.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, en=1, dec_in=3 -> dec_out=4'b0000, y=0, out_valid=0 throughout.
- Legacy sequence, en=1, dec_in=2'b10 (i1=1, i0=0) -> dec_out=4'b0100 every time. Apply mux_sel 2, 0, 3, 1 on consecutive valid cycles -> y = 1, 0, 0, 0 one cycle after each; out_valid=1 each cycle.
- Enable off: en=0, dec_in=2, mux_sel=2, in_valid=1 -> next cycle dec_out=0, y=0, out_valid=1.
- Exhaustive sweep: all 32 combos of en/dec_in/mux_sel at full rate -> dec_out == onehot(dec_in, en) and y == (en && mux_sel==dec_in), each checked one cycle later.
- Hold and mid-stream reset:
  - Load dec_in=1, mux_sel=1, en=1 -> dec_out=4'b0010, y=1.
  - Drop in_valid for 3 cycles with changing inputs -> outputs hold, out_valid=0.
  - Pulse rst -> outputs 0 at the next edge.
- Parameter check: SEL_W=3, dec_in=7, mux_sel=7, en=1 -> dec_out=8'h80, y=1; mux_sel=6 -> y=0.
